// File: rtl/seq_pkg.sv
// Shared opcodes, FSM encoding and default geometry for the instruction sequencer.
package seq_pkg;

  localparam int DEPTH_DEF     = 16;
  localparam int AW_DEF        = 4;
  localparam int IW_DEF        = 16;
  localparam int MAX_STEPS_DEF = 255;
  localparam int STEP_W        = 8;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturating step increment; the counter never moves past the limit.
  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v,
                                                input logic [STEP_W-1:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/prog_buffer.sv
// Program buffer: DEPTH x IW register file, synchronous write, combinational read,
// every entry resets to a HALT word so an unloaded program ends immediately.
module prog_buffer
  import seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  localparam logic [IW-1:0] HALT_WORD = {OP_HALT, {(IW-4){1'b0}}};

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= HALT_WORD;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches buffered instructions from address 0, issues them over
// valid/ready, consumes HALT/JMP internally and aborts with err on the step limit.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = AW_DEF,
  parameter int IW        = IW_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc
);

  localparam logic [STEP_W-1:0] STEP_LIM = STEP_W'(MAX_STEPS);
  localparam logic [AW-1:0]     LAST_PC  = AW'(DEPTH - 1);

  state_t              state, state_nx;
  logic [AW-1:0]       pc_nx;
  logic [STEP_W-1:0]   steps, steps_nx, steps_inc;
  logic [IW-1:0]       instr_nx;
  logic                err_nx;
  logic [IW-1:0]       rd_data;
  logic [3:0]          opcode;

  // Writes are accepted only while idle, so the buffer is frozen during a run.
  prog_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_en && (state == IDLE)),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  assign opcode    = rd_data[IW-1:IW-4];
  assign steps_inc = sat_inc(steps, STEP_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      steps <= '0;
      instr <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      steps <= steps_nx;
      instr <= instr_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    steps_nx = steps;
    instr_nx = instr;
    err_nx   = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          pc_nx    = '0;
          steps_nx = '0;
          err_nx   = 1'b0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        instr_nx = rd_data;
        steps_nx = steps_inc;
        if (opcode == OP_HALT) begin
          state_nx = DONE;
        end else if (opcode == OP_JMP) begin
          pc_nx = rd_data[AW-1:0];
          if (steps_inc == STEP_LIM) begin
            err_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = FETCH;
          end
        end else begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          if (steps == STEP_LIM) begin
            err_nx   = 1'b1;
            state_nx = DONE;
          end else if (pc == LAST_PC) begin
            state_nx = DONE;
          end else begin
            pc_nx    = pc + AW'(1);
            state_nx = FETCH;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign instr_valid = (state == ISSUE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: per-cycle vector table for straight-line and backpressure runs,
// plus hand-written sequences for step limit, run-off-end, ignored requests and reset.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic        instr_ready = 1'b0;

  logic        busy, done, err, instr_valid;
  logic [15:0] instr;
  logic [3:0]  pc;
  logic        l_busy, l_done, l_err, l_valid;
  logic [15:0] l_instr;
  logic [3:0]  l_pc;

  int checks = 0;
  int errors = 0;

  logic [15:0] qd[$];
  logic [15:0] ql[$];

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .busy(busy), .done(done), .err(err),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc)
  );

  instr_sequencer #(.MAX_STEPS(8)) dut_lim (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .busy(l_busy), .done(l_done), .err(l_err),
    .instr(l_instr), .instr_valid(l_valid), .instr_ready(instr_ready), .pc(l_pc)
  );

  // Record every accepted instruction; ready is stable mid-cycle.
  always @(negedge clk) begin
    if (instr_valid && instr_ready) qd.push_back(instr);
    if (l_valid && instr_ready) ql.push_back(l_instr);
  end

  typedef struct {
    logic        go;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic        valid;
    logic [15:0] instr;
    logic [3:0]  pc;
  } vec_t;

  vec_t tbl[21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic load_prog_a();
    load(4'd0, 16'h0020);
    load(4'd1, 16'h0031);
    load(4'd2, 16'hD012);
    load(4'd3, 16'hF000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Start a run on the default DUT and wait for done; n is the cycle done appears.
  task automatic run_wait(output int n);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 2000) begin
      step();
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL run_timeout: done not seen after %0d cycles", n);
    end
    step();
  endtask

  initial begin
    int n;
    int base, lbase;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 4'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0031, 4'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0031, 4'd2};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hD012, 4'd2};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hD012, 4'd3};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hF000, 4'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF000, 4'd3};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF000, 4'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 4'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 4'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0031, 4'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0031, 4'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0031, 4'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0031, 4'd1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0031, 4'd2};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hD012, 4'd2};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hD012, 4'd3};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hF000, 4'd3};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF000, 4'd3};

    // Reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_lim_busy", 32'(l_busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Straight-line run followed by the backpressure run
    load_prog_a();
    base = qd.size();
    for (int i = 0; i < 21; i++) begin
      instr_ready = tbl[i].rdy;
      start = tbl[i].go;
      step();
      start = 1'b0;
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(tbl[i].instr));
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
    end
    chk("vec_accepts", 32'(qd.size() - base), 32'd6);
    instr_ready = 1'b1;

    // Ignored start/load while busy, then confirm buf[1] untouched
    base = qd.size();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    load_en = 1'b1;
    load_addr = 4'd1;
    load_data = 16'hAAAA;
    step();
    start = 1'b0;
    load_en = 1'b0;
    n = 3;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk("ign_done_cycle", 32'(n), 32'd8);
    step();
    chk("ign_busy_after", 32'(busy), 32'd0);
    run_wait(n);
    chk("ign_accepts", 32'(qd.size() - base), 32'd6);
    if (qd.size() - base == 6) begin
      chk("ign_i0", 32'(qd[base+0]), 32'h0020);
      chk("ign_i1", 32'(qd[base+1]), 32'h0031);
      chk("ign_i2", 32'(qd[base+2]), 32'hD012);
      chk("ign_i3", 32'(qd[base+3]), 32'h0020);
      chk("ign_i4", 32'(qd[base+4]), 32'h0031);
      chk("ign_i5", 32'(qd[base+5]), 32'hD012);
    end

    // Run off the end of the buffer
    for (int a = 0; a < 16; a++) load(4'(a), 16'h1111);
    base = qd.size();
    run_wait(n);
    chk("end_done_cycle", 32'(n), 32'd33);
    chk("end_accepts", 32'(qd.size() - base), 32'd16);
    for (int k = base; k < qd.size(); k++) chk("end_instr", 32'(qd[k]), 32'h1111);
    chk("end_pc", 32'(pc), 32'd15);
    chk("end_err", 32'(err), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);

    // Reset while in ISSUE
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_valid_pre", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(instr_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_instr", 32'(instr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    base = qd.size();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_fetch_busy", 32'(busy), 32'd1);
    chk("mid_fetch_done", 32'(done), 32'd0);
    step();
    chk("mid_done", 32'(done), 32'd1);
    chk("mid_done_instr", 32'(instr), 32'hF000);
    step();
    chk("mid_idle_done", 32'(done), 32'd0);
    chk("mid_no_issue", 32'(qd.size() - base), 32'd0);

    // Step limit: MAX_STEPS=8 instance, and 255 on the default instance
    load(4'd0, 16'h0020);
    load(4'd1, 16'hE000);
    base = qd.size();
    lbase = ql.size();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!l_done && n < 100) begin
      step();
      n++;
    end
    chk("lim_done_cycle", 32'(n), 32'd13);
    chk("lim_err", 32'(l_err), 32'd1);
    chk("lim_pc", 32'(l_pc), 32'd0);
    chk("lim_accepts", 32'(ql.size() - lbase), 32'd4);
    step();
    n++;
    chk("lim_err_held", 32'(l_err), 32'd1);
    chk("lim_busy_after", 32'(l_busy), 32'd0);
    while (!done && n < 1000) begin
      step();
      n++;
    end
    chk("max_done_cycle", 32'(n), 32'd384);
    chk("max_err", 32'(err), 32'd1);
    chk("max_accepts", 32'(qd.size() - base), 32'd128);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lim_err_clear", 32'(l_err), 32'd0);
    chk("max_err_clear", 32'(err), 32'd0);
    do_reset();
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
